// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: CPU request/response, RAM port and board I/O of the memory-mapped responder.
interface mem_io_responder_if;
    logic        mem_r;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mio_ready;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;
    logic [15:0] sw;
    logic [15:0] led;
    modport master (
        output mem_r, mem_w, addr, wdata, ram_dout, sw,
        input  rdata, mio_ready, ram_addr, ram_din, ram_we, led
    );
    modport slave (
        input  mem_r, mem_w, addr, wdata, ram_dout, sw,
        output rdata, mio_ready, ram_addr, ram_din, ram_we, led
    );
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: steers CPU requests to RAM, switches, LED register and cycle counter with a fixed 2-cycle latency.
module mem_io_responder (
    input logic               clk,
    input logic               reset,
    mem_io_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, READY = 2'd2} state_t;
    typedef enum logic [2:0] {RG_RAM, RG_SW, RG_LED, RG_CNT, RG_NONE} region_t;
    state_t      state_q, state_d;
    region_t     region;
    logic [13:0] addr_q;
    logic [31:0] wdata_q, cnt_q, cnt_smp_q, rdata_q, rd_sel;
    logic [15:0] sw_q, led_q;
    logic        wr_q, req, addr_unused;
    // Only the region nibble and word index are kept: {addr[31:28], addr[11:2]}
    assign addr_unused = ^{bus.addr[27:12], bus.addr[1:0]};
    always_comb begin
        req = bus.mem_r | bus.mem_w;
        state_d = IDLE;
        if (state_q == IDLE && req) state_d = ACCESS;
        else if (state_q == ACCESS) state_d = READY;
        region = !addr_q[13] ? RG_RAM :
                 addr_q[13:10] == 4'hE ? RG_SW :
                 addr_q[13:10] == 4'hF ? (addr_q[0] ? RG_CNT : RG_LED) : RG_NONE;
        rd_sel = region == RG_RAM ? bus.ram_dout :
                 region == RG_SW  ? {16'h0, sw_q} :
                 region == RG_LED ? {16'h0, led_q} :
                 region == RG_CNT ? cnt_smp_q : 32'h0;
        bus.ram_addr = state_q == ACCESS ? addr_q[9:0] : 10'h0;
        bus.ram_din = wdata_q;
        bus.ram_we = state_q == ACCESS && wr_q && region == RG_RAM;
        bus.mio_ready = state_q == READY;
        // Every source is already a register, so read data can accompany the strobe
        bus.rdata = state_q == READY && !wr_q ? rd_sel : rdata_q;
        bus.led = led_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q <= '0;
            wdata_q <= '0;
            wr_q <= 1'b0;
            cnt_q <= '0;
            cnt_smp_q <= '0;
            rdata_q <= '0;
            sw_q <= '0;
            led_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_q + 32'd1;
            sw_q <= bus.sw;
            if (state_q == IDLE && req) begin
                addr_q <= {bus.addr[31:28], bus.addr[11:2]};
                wdata_q <= bus.wdata;
                wr_q <= bus.mem_w;
            end
            if (state_q == ACCESS) cnt_smp_q <= cnt_q;
            if (state_q == ACCESS && wr_q && region == RG_LED) led_q <= wdata_q[15:0];
            if (state_q == READY && !wr_q) rdata_q <= rd_sel;
        end
    end
endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 mem_r  input  1  CPU read request, level, held until mio_ready seen.
REQ-004 mem_w  input  1  CPU write request, level, held until mio_ready seen.
REQ-005 addr  input  32  CPU byte address; bits [1:0] ignored.
REQ-006 wdata  input  32  CPU write data.
REQ-007 rdata  output  32  read data returned to CPU.
REQ-008 mio_ready  output  1  one-cycle completion strobe to CPU.
REQ-009 ram_addr  output  10  word address to synchronous RAM.
REQ-010 ram_din  output  32  RAM write data.
REQ-011 ram_we  output  1  RAM write enable.
REQ-012 ram_dout  input  32  RAM read data, valid one cycle after ram_addr.
REQ-013 sw  input  16  switch inputs.
REQ-014 led  output  16  LED register.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS and READY, encoded 2 bits; the unused code SHALL go to IDLE.
REQ-016 In IDLE with mem_r or mem_w high, the block SHALL latch addr, wdata and the request type, and go to ACCESS next cycle.
REQ-017 If mem_r and mem_w are both high in IDLE, the block SHALL treat the request as a write.
REQ-018 ACCESS SHALL last exactly one cycle, then go to READY.
REQ-019 READY SHALL last exactly one cycle, then go to IDLE.
REQ-020 mio_ready SHALL be 1 only in READY, so latency is request-seen cycle N -> mio_ready in cycle N+2.
REQ-021 A request still high in IDLE after READY SHALL start a new transaction; no request-edge detection.
REQ-022 Address map by latched addr[31:28]:
  - 0x0-0x7: RAM, word addr[11:2].
  - 0xE: switches, read-only.
  - 0xF with addr[2]=0: LED register.
  - 0xF with addr[2]=1: cycle counter, read-only.
  - All other codes: unmapped.
REQ-023 ram_addr SHALL be driven from latched addr[11:2] in ACCESS, and 0 otherwise.
REQ-024 ram_din SHALL equal the latched wdata.
REQ-025 ram_we SHALL be 1 only in ACCESS, and only for a write to the RAM region.
REQ-026 A write to the LED register SHALL load led <= latched wdata[15:0] at the end of ACCESS.
REQ-027 Writes to switches, counter or unmapped addresses SHALL have no effect, but SHALL still complete with mio_ready.
REQ-028 In READY, rdata SHALL be registered from the selected source:
  - RAM: ram_dout.
  - Switches: {16'b0, sw}.
  - LED: {16'b0, led}.
  - Counter: counter value sampled in ACCESS.
  - Unmapped: 0.
REQ-029 rdata SHALL hold its value until the next READY.
REQ-030 rdata SHALL be unchanged by write transactions.
REQ-031 The 32-bit cycle counter SHALL increment every cycle, wrap from 0xFFFFFFFF to 0, and ignore requests.
REQ-032 sw SHALL be registered once before use.
REQ-033 Requests asserted during ACCESS or READY SHALL be ignored until IDLE.

Reset
REQ-034 Reset SHALL force:
  - state IDLE
  - mio_ready 0
  - ram_we 0
  - ram_addr 0
  - rdata 0
  - led 0
  - counter 0
  - all latched request registers 0
REQ-035 Reset asserted during ACCESS SHALL suppress ram_we and any LED update; no mio_ready SHALL follow.
REQ-036 After reset deasserts, the first request SHALL be accepted in the first IDLE cycle.

Verification
REQ-037 RAM write then read:
  - Stimulus: mem_w, addr 0x00000010, wdata 0xDEADBEEF.
  - Response: ram_we=1, ram_addr=4 in cycle N+1; mio_ready in N+2.
  - Then mem_r at the same address: rdata=0xDEADBEEF with mio_ready.
REQ-038 LED write and readback:
  - Stimulus: write 0x0000A5A5 to 0xF0000000.
  - Response: led=0xA5A5 after ACCESS.
  - Read of 0xF0000000 returns 0x0000A5A5.
REQ-039 Switch and unmapped reads:
  - sw=0x1234, read 0xE0000000 -> rdata=0x00001234.
  - Read of 0x90000000 -> rdata=0, mio_ready still pulses.
REQ-040 Simultaneous and held requests:
  - mem_r=mem_w=1 -> treated as write, ram_we=1.
  - Request held high across READY -> second mio_ready exactly 3 cycles after the first.
REQ-041 Reset mid-operation:
  - Assert reset in ACCESS of a RAM write -> ram_we=0, no mio_ready, led=0, counter=0.
REQ-042 Counter:
  - Two counter reads issued 10 cycles apart (IDLE-to-IDLE) -> values differ by exactly 10.
  - Force counter to 0xFFFFFFFF -> next cycle reads 0.
